// File: rtl/decoder_seq_pkg.sv
// decoder_seq shared package: state encoding and default widths.
// Imported by decoder_seq and onehot_dec.
package decoder_seq_pkg;

  localparam int IN_W_DEF  = 4;
  localparam int OUT_W_DEF = 2 ** IN_W_DEF;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// onehot_dec: combinational index to one-hot decoder.
// Ports: idx (IN_W) in, onehot (OUT_W) out.
module onehot_dec
  import decoder_seq_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// decoder_seq: sequenced 4-to-16 one-hot line driver with scan mode.
// Ports: clk, rst_n, enable, in_valid/in_ready, binary_in, pulse_len,
//        scan_mode in; decoder_out, busy, done registered out.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  binary_in,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic             scan_mode,
  output logic [OUT_W-1:0] decoder_out,
  output logic             busy,
  output logic             done
);

  localparam logic [IN_W:0] LAST_LINE =
    (IN_W+1)'(OUT_W - 1);

  state_t           state, state_n;
  logic [IN_W-1:0]  cur_idx, idx_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic             scan_q, scan_n;
  logic [IN_W:0]    line_cnt, line_n;
  logic [LEN_W-1:0] pulse_cnt, cnt_n;
  logic [OUT_W-1:0] out_n;
  logic             done_n;
  logic             busy_n;

  logic [IN_W-1:0]  dec_idx;
  logic [OUT_W-1:0] dec_out;
  logic [IN_W-1:0]  idx_inc;
  logic [LEN_W-1:0] eff_len;

  assign in_ready = (state == IDLE) && enable;
  assign idx_inc  = cur_idx + IN_W'(1);
  // A zero length request still drives its line for one cycle.
  assign eff_len  = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

  onehot_dec #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .idx    (dec_idx),
    .onehot (dec_out)
  );

  always_comb begin
    state_n = state;
    idx_n   = cur_idx;
    len_n   = len_q;
    scan_n  = scan_q;
    line_n  = line_cnt;
    cnt_n   = pulse_cnt;
    out_n   = '0;
    done_n  = 1'b0;
    dec_idx = cur_idx;
    if (!enable) begin
      state_n = IDLE;
      line_n  = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          dec_idx = binary_in;
          if (in_valid) begin
            state_n = DRIVE;
            idx_n   = binary_in;
            len_n   = eff_len;
            scan_n  = scan_mode;
            line_n  = '0;
            cnt_n   = eff_len - LEN_W'(1);
            out_n   = dec_out;
          end
        end
        DRIVE: begin
          if (pulse_cnt != '0) begin
            cnt_n = pulse_cnt - LEN_W'(1);
            out_n = dec_out;
          end else if (scan_q &&
                       line_cnt != LAST_LINE) begin
            state_n = GAP;
            line_n  = line_cnt + (IN_W+1)'(1);
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        GAP: begin
          // Decode the next line now so it is
          // registered on entry to DRIVE.
          dec_idx = idx_inc;
          idx_n   = idx_inc;
          cnt_n   = len_q - LEN_W'(1);
          state_n = DRIVE;
          out_n   = dec_out;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_idx     <= '0;
      len_q       <= '0;
      scan_q      <= 1'b0;
      line_cnt    <= '0;
      pulse_cnt   <= '0;
      decoder_out <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cur_idx     <= idx_n;
      len_q       <= len_n;
      scan_q      <= scan_n;
      line_cnt    <= line_n;
      pulse_cnt   <= cnt_n;
      decoder_out <= out_n;
      done        <= done_n;
      busy        <= busy_n;
    end
  end

endmodule
